// File: rtl/ark_round_engine_if.sv
// ark_round_engine_if: request/result handshake bundle for the add-round-key engine
interface ark_round_engine_if #(
    parameter int KEY_W = 80
);
    logic             i_valid;
    logic             o_ready;
    logic             i_dec;
    logic [63:0]      i_msg;
    logic [KEY_W-1:0] i_key;
    logic             o_valid;
    logic             i_ready;
    logic [63:0]      o_cipher;
    logic [KEY_W-1:0] o_key_last;
    logic             o_busy;

    modport master (
        output i_valid, i_dec, i_msg, i_key, i_ready,
        input  o_ready, o_valid, o_cipher, o_key_last, o_busy
    );

    modport slave (
        input  i_valid, i_dec, i_msg, i_key, i_ready,
        output o_ready, o_valid, o_cipher, o_key_last, o_busy
    );
endinterface

// File: rtl/ark_round_engine.sv
// ark_round_engine: iterative add-round-key engine with forward/inverse key schedule
module ark_round_engine #(
    parameter int KEY_W  = 80,
    parameter int ROUNDS = 25
) (
    input logic              i_clk,
    input logic              i_rst,
    ark_round_engine_if.slave bus
);
    // nibble i of each table holds S(i) / S^-1(i)
    localparam logic [63:0] SBOX     = 64'h6358_F02D_AC97_1B4E;
    localparam logic [63:0] SBOX_INV = 64'hB086_275C_4FD1_E93A;
    localparam logic [4:0]  RLAST    = 5'(ROUNDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_n;
    logic [63:0]      s_q;
    logic [KEY_W-1:0] k_q, k_next, k_prev;
    logic [4:0]       rc;
    logic             dec_q;
    logic             last;
    logic             accept;

    function automatic logic [KEY_W-1:0] next_key(input logic [KEY_W-1:0] k, input logic [4:0] r);
        logic [KEY_W-1:0] t;
        t        = {k[KEY_W-14:0], k[KEY_W-1:KEY_W-13]};
        t[3:0]   = SBOX[{t[3:0], 2'b00} +: 4];
        t[63:59] = t[63:59] ^ r;
        return t;
    endfunction

    function automatic logic [KEY_W-1:0] prev_key(input logic [KEY_W-1:0] k, input logic [4:0] r);
        logic [KEY_W-1:0] t;
        t        = k;
        t[63:59] = t[63:59] ^ r;
        t[3:0]   = SBOX_INV[{t[3:0], 2'b00} +: 4];
        return {t[12:0], t[KEY_W-1:13]};
    endfunction

    assign k_next = next_key(k_q, rc);
    assign k_prev = prev_key(k_q, RLAST - rc);
    assign last   = rc == RLAST;
    assign accept = state == IDLE && bus.i_valid;

    assign bus.o_ready    = state == IDLE;
    assign bus.o_busy     = state == RUN;
    assign bus.o_valid    = state == DONE;
    assign bus.o_cipher   = s_q;
    assign bus.o_key_last = k_q;

    // state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_n;
    end

    // next state: accept in IDLE, leave RUN after the last round, drain DONE on i_ready
    always_comb begin
        state_n = state;
        if (accept)                          state_n = RUN;
        else if (state == RUN && last)       state_n = DONE;
        else if (state == DONE && bus.i_ready) state_n = IDLE;
    end

    // datapath: load on accept, one round per RUN cycle, hold otherwise
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s_q   <= '0;
            k_q   <= '0;
            rc    <= '0;
            dec_q <= 1'b0;
        end else if (accept) begin
            s_q   <= bus.i_msg;
            k_q   <= bus.i_key;
            rc    <= '0;
            dec_q <= bus.i_dec;
        end else if (state == RUN) begin
            s_q <= s_q ^ (dec_q ? k_prev[63:0] : k_q[63:0]);
            k_q <= dec_q ? k_prev : k_next;
            rc  <= last ? rc : rc + 5'd1;
        end
    end
endmodule

// File: tb/tb_ark_round_engine.sv
// tb_ark_round_engine: directed vectors and corner sequences for ark_round_engine
module tb_ark_round_engine;
    logic         clk, rst;
    logic [1:0]   sel;
    logic         valid, dec, rdy;
    logic [63:0]  msg;
    logic [127:0] key;
    logic         mv, mr, mb;
    logic [63:0]  mc;
    logic [127:0] mk;
    int           tests, fails;

    ark_round_engine_if #(.KEY_W(80))  b1 ();
    ark_round_engine_if #(.KEY_W(80))  b2 ();
    ark_round_engine_if #(.KEY_W(80))  b3 ();
    ark_round_engine_if #(.KEY_W(128)) b4 ();

    ark_round_engine #(.KEY_W(80),  .ROUNDS(1))  u1 (.i_clk(clk), .i_rst(rst), .bus(b1.slave));
    ark_round_engine #(.KEY_W(80),  .ROUNDS(2))  u2 (.i_clk(clk), .i_rst(rst), .bus(b2.slave));
    ark_round_engine #(.KEY_W(80),  .ROUNDS(25)) u3 (.i_clk(clk), .i_rst(rst), .bus(b3.slave));
    ark_round_engine #(.KEY_W(128), .ROUNDS(25)) u4 (.i_clk(clk), .i_rst(rst), .bus(b4.slave));

    assign b1.i_valid = valid && sel == 2'd0;
    assign b2.i_valid = valid && sel == 2'd1;
    assign b3.i_valid = valid && sel == 2'd2;
    assign b4.i_valid = valid && sel == 2'd3;
    assign b1.i_dec = dec;  assign b2.i_dec = dec;  assign b3.i_dec = dec;  assign b4.i_dec = dec;
    assign b1.i_msg = msg;  assign b2.i_msg = msg;  assign b3.i_msg = msg;  assign b4.i_msg = msg;
    assign b1.i_ready = rdy; assign b2.i_ready = rdy; assign b3.i_ready = rdy; assign b4.i_ready = rdy;
    assign b1.i_key = key[79:0];
    assign b2.i_key = key[79:0];
    assign b3.i_key = key[79:0];
    assign b4.i_key = key;

    assign mv = sel == 0 ? b1.o_valid : sel == 1 ? b2.o_valid : sel == 2 ? b3.o_valid : b4.o_valid;
    assign mr = sel == 0 ? b1.o_ready : sel == 1 ? b2.o_ready : sel == 2 ? b3.o_ready : b4.o_ready;
    assign mb = sel == 0 ? b1.o_busy  : sel == 1 ? b2.o_busy  : sel == 2 ? b3.o_busy  : b4.o_busy;
    assign mc = sel == 0 ? b1.o_cipher : sel == 1 ? b2.o_cipher : sel == 2 ? b3.o_cipher : b4.o_cipher;
    assign mk = sel == 0 ? {48'd0, b1.o_key_last} : sel == 1 ? {48'd0, b2.o_key_last} :
                sel == 2 ? {48'd0, b3.o_key_last} : b4.o_key_last;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] msg;
        logic [79:0] key;
        logic        dec;
        logic [63:0] c;
        logic [79:0] k;
    } vec_t;

    vec_t tv[10];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic op(input logic [1:0] s, input logic d, input logic [63:0] m, input logic [127:0] k,
                      output logic [63:0] c, output logic [127:0] kl);
        int n;
        int rounds;
        rounds = s == 0 ? 1 : s == 1 ? 2 : 25;
        sel = s; dec = d; msg = m; key = k; valid = 1'b1; rdy = 1'b0;
        @(posedge clk); #1;
        valid = 1'b0; msg = ~m; key = ~k; dec = ~d;
        chk("busy_after_accept", {127'd0, mb}, 128'd1);
        n = 1;
        while (!mv && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency_edges", 128'(n), 128'(rounds + 1));
        c = mc;
        kl = mk;
        rdy = 1'b1;
        @(posedge clk); #1;
        rdy = 1'b0;
        chk("ready_after_done", {126'd0, mr, mv}, 128'd2);
    endtask

    task automatic round_trip(input logic [1:0] s, input logic [127:0] k0, input logic [63:0] m0);
        logic [63:0]  c, c2;
        logic [127:0] kl, kl2;
        op(s, 1'b0, m0, k0, c, kl);
        op(s, 1'b1, c, kl, c2, kl2);
        chk("round_trip_msg", {64'd0, c2}, {64'd0, m0});
        chk("round_trip_key", kl2, k0);
    endtask

    initial begin
        logic [63:0]  c, hc;
        logic [127:0] kl, hk, rk;
        tests = 0; fails = 0;
        tv[0] = '{64'h0, 80'h0, 1'b0, 64'h0, 80'hE};
        tv[1] = '{64'h0, 80'h1, 1'b0, 64'h1, 80'h200E};
        tv[2] = '{64'hDEAD_BEEF_0123_4567, 80'h8000_0000_0000_0000_0000, 1'b0, 64'hDEAD_BEEF_0123_4567, 80'h100E};
        tv[3] = '{64'h1234, 80'hFFFF_0000_0000_0000_0005, 1'b0, 64'h1231, 80'hE000_0000_0000_0000_BFF6};
        tv[4] = '{64'h0, 80'h0028_0000_0000_0000_0000, 1'b0, 64'h0, 80'h9};
        tv[5] = '{64'h0, 80'h0000_FFFF_FFFF_FFFF_FFFF, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 80'h1FFF_FFFF_FFFF_FFFF_E00E};
        tv[6] = '{64'h0, 80'h200E, 1'b1, 64'h1, 80'h1};
        tv[7] = '{64'hFF, 80'h9, 1'b1, 64'hFF, 80'h0028_0000_0000_0000_0000};
        tv[8] = '{64'h1231, 80'hE000_0000_0000_0000_BFF6, 1'b1, 64'h1234, 80'hFFFF_0000_0000_0000_0005};
        tv[9] = '{64'hFFFF_FFFF_FFFF_FFFF, 80'h1FFF_FFFF_FFFF_FFFF_E00E, 1'b1, 64'h0, 80'h0000_FFFF_FFFF_FFFF_FFFF};

        rst = 1'b1; sel = 2'd0; valid = 1'b0; dec = 1'b0; rdy = 1'b0; msg = '0; key = '0;
        #3;
        chk("reset_outputs", {mc, mk[79:0], 45'd0, mr, mv, mb}, {64'd0, 80'd0, 45'd0, 3'b100});
        #9 rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            op(2'd0, tv[i].dec, tv[i].msg, {48'd0, tv[i].key}, c, kl);
            chk($sformatf("vec%0d_cipher", i), {64'd0, c}, {64'd0, tv[i].c});
            chk($sformatf("vec%0d_key", i), kl, {48'd0, tv[i].k});
        end

        op(2'd1, 1'b0, 64'h0, 128'h0, c, kl);
        chk("ctr_inject_cipher", {64'd0, c}, 128'hE);
        chk("ctr_inject_key", kl, 128'h0000_0800_0000_0001_C00E);
        op(2'd1, 1'b1, 64'hE, 128'h0000_0800_0000_0001_C00E, c, kl);
        chk("ctr_inject_inv_cipher", {64'd0, c}, 128'h0);
        chk("ctr_inject_inv_key", kl, 128'h0);

        rk = {$urandom, $urandom, $urandom, $urandom};
        round_trip(2'd2, {48'd0, rk[79:0]}, 64'h7777_aaaa_3333_eeee);
        rk = {$urandom, $urandom, $urandom, $urandom};
        round_trip(2'd3, rk, 64'h7777_aaaa_3333_eeee);

        rk = {48'd0, $urandom, $urandom, 16'(($urandom))};
        sel = 2'd2; dec = 1'b0; msg = 64'h7777_aaaa_3333_eeee; key = rk; valid = 1'b1; rdy = 1'b0;
        @(posedge clk); #1 valid = 1'b0;
        for (int n = 0; n < 100 && !mv; n++) begin
            @(posedge clk); #1;
        end
        chk("bp_reached_done", {127'd0, mv}, 128'd1);
        hc = mc;
        hk = mk;
        for (int i = 0; i < 10; i++) begin
            valid = i[0];
            msg = {$urandom, $urandom};
            key = ~key;
            dec = ~i[0];
            @(posedge clk); #1;
            chk("bp_hold", {mc, mk[79:0], 46'd0, mr, mv}, {hc, hk[79:0], 46'd0, 2'b01});
        end
        valid = 1'b0; rdy = 1'b1;
        @(posedge clk); #1 rdy = 1'b0;
        chk("bp_release_idle", {126'd0, mr, mv}, 128'd2);
        op(2'd2, 1'b1, hc, hk, c, kl);
        chk("bp_inverse_msg", {64'd0, c}, 128'h7777_aaaa_3333_eeee);
        chk("bp_inverse_key", kl, rk);

        sel = 2'd2; dec = 1'b0; msg = 64'h0123_4567_89AB_CDEF; key = 128'h5555_AAAA_0F0F_F0F0_1234; valid = 1'b1;
        @(posedge clk); #1 valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("midrun_busy", {127'd0, mb}, 128'd1);
        rst = 1'b1;
        #1;
        chk("midrun_reset_outputs", {mc, mk[79:0], 45'd0, mr, mv, mb}, {64'd0, 80'd0, 45'd0, 3'b100});
        #2 rst = 1'b0;
        @(posedge clk); #1;
        chk("after_reset_idle", {126'd0, mr, mv}, 128'd2);
        op(2'd0, 1'b0, 64'h0, 128'h1, c, kl);
        chk("after_reset_cipher", {64'd0, c}, 128'h1);
        chk("after_reset_key", kl, 128'h200E);
        round_trip(2'd2, 128'h1234_5678_9ABC_DEF0_1357, 64'h7777_aaaa_3333_eeee);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
